// File: rtl/ray_pixel_source.sv
// Ready/valid raster coordinate source: walks H_RES x V_RES pixels, one beat per handshake.
// Optional inter-beat throttle gap enabled by defining RAY_PIXEL_SOURCE_THROTTLE_EN.
module ray_pixel_source #(
  parameter int X_WIDTH    = 10,
  parameter int Y_WIDTH    = 10,
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int GAP_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic               ready,
  output logic               valid,
  output logic [X_WIDTH-1:0] pix_x,
  output logic [Y_WIDTH-1:0] pix_y,
  output logic               last,
  output logic               busy,
  output logic               done
);

  localparam logic [X_WIDTH-1:0] X_LAST        = X_WIDTH'(H_RES - 1);
  localparam logic [Y_WIDTH-1:0] Y_LAST        = Y_WIDTH'(V_RES - 1);
  localparam logic               FIRST_IS_LAST = (H_RES == 1) && (V_RES == 1);

`ifdef RAY_PIXEL_SOURCE_THROTTLE_EN
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  logic [GAP_W-1:0] r_gap_cnt;
  logic             w_pos_last;
`else
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1
  } state_t;

  logic             w_next_last;
`endif

  state_t             r_state;
  logic               r_valid;
  logic [X_WIDTH-1:0] r_pix_x;
  logic [Y_WIDTH-1:0] r_pix_y;
  logic               r_last;
  logic               r_busy;
  logic               r_done;

  logic               w_hs;
  logic               w_at_x_last;
  logic [X_WIDTH-1:0] w_next_x;
  logic [Y_WIDTH-1:0] w_next_y;

  assign w_hs        = r_valid & ready;
  assign w_at_x_last = (r_pix_x == X_LAST);
  assign w_next_x    = w_at_x_last ? '0 : r_pix_x + X_WIDTH'(1);
  assign w_next_y    = w_at_x_last ? r_pix_y + Y_WIDTH'(1) : r_pix_y;

`ifdef RAY_PIXEL_SOURCE_THROTTLE_EN
  assign w_pos_last  = (r_pix_x == X_LAST) && (r_pix_y == Y_LAST);
`else
  assign w_next_last = (w_next_x == X_LAST) && (w_next_y == Y_LAST);
`endif

  // Frame FSM; every output is a register updated here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_valid   <= 1'b0;
      r_pix_x   <= '0;
      r_pix_y   <= '0;
      r_last    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
`ifdef RAY_PIXEL_SOURCE_THROTTLE_EN
      r_gap_cnt <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          // abort is meaningless here, so start always wins
          if (start) begin
            r_state <= S_SEND;
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
            r_pix_x <= '0;
            r_pix_y <= '0;
            r_last  <= FIRST_IS_LAST;
          end
        end

        S_SEND: begin
          if (abort) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_pix_x <= '0;
            r_pix_y <= '0;
            r_last  <= 1'b0;
          end else if (w_hs) begin
            if (r_last) begin
              r_state <= S_IDLE;
              r_valid <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_pix_x <= '0;
              r_pix_y <= '0;
              r_last  <= 1'b0;
            end else begin
              r_pix_x <= w_next_x;
              r_pix_y <= w_next_y;
`ifdef RAY_PIXEL_SOURCE_THROTTLE_EN
              // next coordinate is staged during the gap, last re-derived on reassert
              r_state   <= S_GAP;
              r_valid   <= 1'b0;
              r_last    <= 1'b0;
              r_gap_cnt <= GAP_W'(GAP_CYCLES - 1);
`else
              r_last  <= w_next_last;
`endif
            end
          end
        end

`ifdef RAY_PIXEL_SOURCE_THROTTLE_EN
        S_GAP: begin
          if (abort) begin
            r_state   <= S_IDLE;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_pix_x   <= '0;
            r_pix_y   <= '0;
            r_last    <= 1'b0;
            r_gap_cnt <= '0;
          end else if (r_gap_cnt == '0) begin
            r_state <= S_SEND;
            r_valid <= 1'b1;
            r_last  <= w_pos_last;
          end else begin
            r_gap_cnt <= r_gap_cnt - GAP_W'(1);
          end
        end
`endif

        default: begin
          r_state <= S_IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_pix_x <= '0;
          r_pix_y <= '0;
          r_last  <= 1'b0;
        end
      endcase
    end
  end

  assign valid = r_valid;
  assign pix_x = r_pix_x;
  assign pix_y = r_pix_y;
  assign last  = r_last;
  assign busy  = r_busy;
  assign done  = r_done;

endmodule

// File: tb/tb_ray_pixel_source.sv
// Directed + randomized bench for ray_pixel_source on a 4x2 frame, checked each cycle
// against a beat-index reference model (gap model active when the throttle macro is defined).
module tb_ray_pixel_source;

  localparam int XW = 10;
  localparam int YW = 10;
  localparam int H  = 4;
  localparam int V  = 2;
  localparam int N  = H * V;
`ifdef RAY_PIXEL_SOURCE_THROTTLE_EN
  localparam int GAP = 2;
`else
  localparam int GAP = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          ready = 1'b0;
  logic          valid;
  logic [XW-1:0] pix_x;
  logic [YW-1:0] pix_y;
  logic          last;
  logic          busy;
  logic          done;

  int n_vec  = 0;
  int n_fail = 0;

  // reference model: frame active flag, raster beat index, remaining gap cycles
  bit m_active;
  int m_idx;
  int m_gap;
  bit m_done;
  int m_hs;

  ray_pixel_source #(
    .X_WIDTH(XW), .Y_WIDTH(YW), .H_RES(H), .V_RES(V), .GAP_CYCLES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .ready(ready),
    .valid(valid), .pix_x(pix_x), .pix_y(pix_y), .last(last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0; m_idx = 0; m_gap = 0; m_done = 1'b0; m_hs = 0;
  endtask

  function automatic bit model_valid();
    return m_active && (m_gap == 0);
  endfunction

  task automatic check_outputs();
    bit ev;
    ev = model_valid();
    chk("valid", 32'(valid), 32'(ev));
    chk("busy",  32'(busy),  32'(m_active));
    chk("done",  32'(done),  32'(m_done));
    chk("last",  32'(last),  32'(ev && (m_idx == N - 1)));
    if (ev || !m_active) begin
      chk("pix_x", 32'(pix_x), 32'(m_idx % H));
      chk("pix_y", 32'(pix_y), 32'(m_idx / H));
    end
  endtask

  task automatic model_update(input bit s, input bit a, input bit r);
    bit v;
    v = model_valid();
    m_done = 1'b0;
    if (!m_active) begin
      if (s) begin
        m_active = 1'b1; m_idx = 0; m_gap = 0;
      end
    end else begin
      if (v && r) m_hs++;
      if (a) begin
        m_active = 1'b0; m_idx = 0; m_gap = 0;
      end else if (m_gap > 0) begin
        m_gap--;
      end else if (r) begin
        if (m_idx == N - 1) begin
          m_active = 1'b0; m_idx = 0; m_done = 1'b1;
        end else begin
          m_idx++; m_gap = GAP;
        end
      end
    end
  endtask

  // check current outputs, apply inputs for the coming edge, advance model
  task automatic step(input bit s, input bit a, input bit r);
    check_outputs();
    start = s; abort = a; ready = r;
    @(posedge clk);
    model_update(s, a, r);
    @(negedge clk);
  endtask

  function automatic bit ready_for(input int mode, input int i);
    logic [5:0] pat;
    pat = 6'b101001;
    if (mode == 0) return 1'b1;
    if (mode == 1) return pat[i % 6];
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic run_frame(input int mode);
    int i;
    i = 0;
    while (m_active && i < 400) begin
      step(1'b0, 1'b0, ready_for(mode, i));
      i++;
    end
    if (m_active) begin
      n_vec++; n_fail++;
      $error("FAIL frame_timeout: observed busy expected idle");
    end
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1);

    // full frame with ready held high
    step(1'b1, 1'b0, 1'b1);
    run_frame(0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);

    // stalls from the fixed ready pattern
    step(1'b1, 1'b0, 1'b0);
    run_frame(1);
    step(1'b0, 1'b0, 1'b0);

    // start+abort together in idle, then abort on the 3rd handshake
    step(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 100 && m_active; i++)
      step(1'b0, (m_hs == 2) && model_valid(), 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    run_frame(0);
    step(1'b0, 1'b0, 1'b1);

    // start while busy ignored; start in done cycle accepted
    step(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 100 && m_active; i++)
      step((m_hs == 4), 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    run_frame(2);
    step(1'b0, 1'b0, 1'b1);

    // asynchronous reset mid-frame at beat 5
    step(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 100 && m_active && m_hs < 5; i++)
      step(1'b0, 1'b0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++)
      step(1'b0, 1'b0, 1'b1);

    // randomized start/abort/ready traffic
    for (int i = 0; i < 600; i++)
      step(($urandom_range(0, 7) == 0), ($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)));
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/ray_pixel_source.md
Name: ray_pixel_source

Overview:
- Ready/valid producer that walks a frame of H_RES x V_RES pixel coordinates and issues one coordinate beat per handshake to a downstream ray-generation consumer.
- It is the transmitting end of the ready/valid link whose receiving end is ready_valid_counter.
- Started by a single-cycle start pulse from the frame controller.
- Reports busy/done back to that controller and honours backpressure from any ready-driven consumer.

Parameters:
X_WIDTH, 10, width of pix_x
Y_WIDTH, 10, width of pix_y
H_RES, 640, pixels per row; 1 <= H_RES <= 2**X_WIDTH
V_RES, 480, rows per frame; 1 <= V_RES <= 2**Y_WIDTH
GAP_CYCLES, 2, idle cycles inserted between beats (throttle feature only); >= 1

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle frame start request
abort  input  1  cancel current frame
ready  input  1  consumer ready
valid  output  1  beat valid
pix_x  output  X_WIDTH  column of current beat
pix_y  output  Y_WIDTH  row of current beat
last  output  1  high with the final beat of the frame
busy  output  1  frame in progress
done  output  1  one-cycle pulse after last beat accepted

Behaviour:
- Reset (rst_n=0, async, any state): valid=0, pix_x=0, pix_y=0, last=0, busy=0, done=0, FSM=IDLE.
- FSM states:
  - IDLE: start=1 -> SEND. In the next cycle valid=1, busy=1, (pix_x,pix_y)=(0,0).
  - SEND: valid held high until handshake (valid&ready).
    - On handshake of a non-last beat: pix_x increments next cycle; at pix_x==H_RES-1 it wraps to 0 and pix_y increments.
    - valid stays 1, so throughput is 1 beat/cycle when ready is held high.
    - On handshake of the last beat: next cycle valid=0, busy=0, done=1 for exactly one cycle, pix_x/pix_y/last return to 0, FSM=IDLE.
- last = (pix_x==H_RES-1 && pix_y==V_RES-1) && valid. It is registered alongside the data.
- Stability: while valid=1 && ready=0, pix_x, pix_y and last must not change, and valid must not drop except via abort or reset.
- ready with valid=0 has no effect. ready is never required before valid asserts.
- start while busy=1 is ignored. start in the done cycle (FSM already IDLE) is accepted.
- abort:
  - In SEND: next cycle valid=0, busy=0, counters=0, no done pulse, FSM=IDLE.
  - Abort in the same cycle as a handshake: the beat counts as delivered (the consumer saw it), but the frame still ends with no done.
  - Abort in IDLE: ignored.
  - abort and start together in IDLE: start wins.
- Degenerate frame H_RES=V_RES=1: a single beat with last=1.
- Counters never exceed H_RES-1 / V_RES-1. No wrap beyond the frame.
- Every frame delivers exactly H_RES*V_RES beats in raster order, with no duplicates or skips.

Optional Feature:
- Macro RAY_PIXEL_SOURCE_THROTTLE_EN.
- Defined:
  - After each non-last handshake, valid drops for exactly GAP_CYCLES cycles, then reasserts with the next coordinate.
  - The gap is counted by an internal down-counter in an extra FSM state GAP.
  - busy stays 1 during GAP.
  - abort during GAP returns to IDLE as above.
  - No gap after the last beat.
- Undefined: no GAP state, no gap counter, and GAP_CYCLES is unused.

Test Plan:
- H_RES=4, V_RES=2, ready=1 constant, start pulse -> valid rises 1 cycle after start.
  - 8 consecutive beats: (0,0),(1,0),(2,0),(3,0),(0,1),(1,1),(2,1),(3,1).
  - last only on (3,1); done=1 one cycle after it; busy=0 from that cycle.
- Same frame, ready pattern 1,0,0,1,0,1,... -> data held stable through every stall.
  - Exactly 8 handshakes, in order; done after the 8th handshake.
- Abort asserted in the cycle of the 3rd handshake -> next cycle valid=0, busy=0, no done.
  - The following start produces a full frame beginning at (0,0).
- start pulsed again at beat 4 -> ignored, sequence unchanged.
  - start pulsed in the done cycle -> a new frame begins with (0,0) next cycle.
- rst_n driven 0 mid-frame at beat 5 (asynchronously, between edges) -> valid/busy/last/pix_x/pix_y go to 0 immediately.
  - After release, no beat until a new start.
- With RAY_PIXEL_SOURCE_THROTTLE_EN and GAP_CYCLES=2, ready=1 -> valid low exactly 2 cycles between consecutive beats.
  - 8 beats complete in 8+7*2=22 valid/gap cycles; done follows the last beat.
